// File: rtl/move_input_pkg.sv
// Shared types for the push-button command front end: command codes,
// arbiter states and the fixed press priority used by move_input_ctrl.
package move_input_pkg;

    localparam int NUM_BTN = 5;

    typedef enum logic [2:0] {
        CMD_NONE  = 3'd0,
        CMD_START = 3'd1,
        CMD_UP    = 3'd2,
        CMD_DOWN  = 3'd3,
        CMD_LEFT  = 3'd4,
        CMD_RIGHT = 3'd5
    } cmd_t;

    typedef enum logic {
        IDLE         = 1'b0,
        WAIT_RELEASE = 1'b1
    } state_t;

    // Index 0 is the highest priority; the press vector uses the same order.
    localparam cmd_t PRIO_ORDER [NUM_BTN] = '{CMD_START, CMD_UP, CMD_DOWN, CMD_LEFT, CMD_RIGHT};

    function automatic cmd_t pick_cmd(input logic [NUM_BTN-1:0] press);
        cmd_t win;
        win = CMD_NONE;
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            if (press[i[2:0]]) win = PRIO_ORDER[i[2:0]];
        end
        return win;
    endfunction

endpackage

// File: rtl/move_input_ctrl_if.sv
// Board-side bundle: raw active-low keys in, one-cycle game commands out.
// master = the conditioner, slave = the board/consumer side.
interface move_input_ctrl_if;

    logic key_start_n;
    logic key_up_n;
    logic key_down_n;
    logic key_left_n;
    logic key_right_n;

    logic start;
    logic mov_up;
    logic mov_down;
    logic mov_left;
    logic mov_right;
    move_input_pkg::cmd_t last_cmd;
    logic busy;

    modport master (
        input  key_start_n, key_up_n, key_down_n, key_left_n, key_right_n,
        output start, mov_up, mov_down, mov_left, mov_right, last_cmd, busy
    );

    modport slave (
        output key_start_n, key_up_n, key_down_n, key_left_n, key_right_n,
        input  start, mov_up, mov_down, mov_left, mov_right, last_cmd, busy
    );

endinterface

// File: rtl/button_debouncer.sv
// One push-button: synchroniser chain, stability counter and a one-cycle
// press flag raised when the debounced level falls.
module button_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input  logic clk_25Mhz,
    input  logic _reset,
    input  logic key_n,
    output logic level,
    output logic press
);

    localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   press_q, press_d;
    logic                   sample;

    assign sample = sync_q[SYNC_STAGES-1];

    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        sync_d  = {sync_q[SYNC_STAGES-2:0], key_n};
        cnt_d   = '0;
        level_d = level_q;
        press_d = 1'b0;
        // Any sample matching the current level clears the count, so bounce restarts it.
        if (sample != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sample;
                press_d = ~sample;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_25Mhz or posedge _reset) begin
        if (_reset) begin
            // NOTE: the chain resets to the released level so reset release cannot look like a press.
            sync_q  <= '1;
            cnt_q   <= '0;
            level_q <= 1'b1;
            press_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/move_input_ctrl.sv
// Five debounced buttons feeding a priority arbiter that issues one
// registered single-cycle command per press, then waits for full release.
module move_input_ctrl
    import move_input_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input logic               clk_25Mhz,
    input logic               _reset,
    move_input_ctrl_if.master bus
);

    logic [NUM_BTN-1:0] keys_n;
    logic [NUM_BTN-1:0] level;
    logic [NUM_BTN-1:0] press;
    state_t             state_q, state_d;
    cmd_t               pulse_q, pulse_d;
    cmd_t               last_cmd_q, last_cmd_d;

    // Bit order follows PRIO_ORDER so bit 0 is the highest-priority button.
    assign keys_n = {bus.key_right_n, bus.key_left_n, bus.key_down_n,
                     bus.key_up_n, bus.key_start_n};

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        button_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .SYNC_STAGES    (SYNC_STAGES)
        ) u_deb (
            .clk_25Mhz(clk_25Mhz),
            ._reset   (_reset),
            .key_n    (keys_n[i]),
            .level    (level[i]),
            .press    (press[i])
        );
    end

    always_comb begin
        state_d    = state_q;
        pulse_d    = CMD_NONE;
        last_cmd_d = last_cmd_q;
        case (state_q)
            IDLE: begin
                if (|press) begin
                    pulse_d    = pick_cmd(press);
                    last_cmd_d = pick_cmd(press);
                    state_d    = WAIT_RELEASE;
                end
            end
            WAIT_RELEASE: begin
                if (&level) state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_25Mhz or posedge _reset) begin
        if (_reset) begin
            state_q    <= IDLE;
            pulse_q    <= CMD_NONE;
            last_cmd_q <= CMD_NONE;
        end else begin
            state_q    <= state_d;
            pulse_q    <= pulse_d;
            last_cmd_q <= last_cmd_d;
        end
    end

    // All commands decode from one registered code, so at most one is active.
    assign bus.start     = (pulse_q == CMD_START);
    assign bus.mov_up    = (pulse_q != CMD_UP);
    assign bus.mov_down  = (pulse_q != CMD_DOWN);
    assign bus.mov_left  = (pulse_q != CMD_LEFT);
    assign bus.mov_right = (pulse_q != CMD_RIGHT);
    assign bus.last_cmd  = last_cmd_q;
    assign bus.busy      = (state_q == WAIT_RELEASE);

endmodule

// File: tb/tb_move_input_ctrl.sv
// Bench for move_input_ctrl: directed press scenarios plus random key traffic,
// all compared each cycle against a sliding-window behavioural model.
module tb_move_input_ctrl;
    import move_input_pkg::*;

    localparam int DEB  = 4;
    localparam int SYNC = 2;
    localparam int NB   = 5;
    localparam int HL   = SYNC + DEB - 1;

    logic clk_25Mhz = 1'b0;
    logic _reset    = 1'b1;
    logic [NB-1:0] keys_n = '1;   // bit 0 start, 1 up, 2 down, 3 left, 4 right

    always #20 clk_25Mhz = ~clk_25Mhz;

    move_input_ctrl_if bus ();

    assign bus.key_start_n = keys_n[0];
    assign bus.key_up_n    = keys_n[1];
    assign bus.key_down_n  = keys_n[2];
    assign bus.key_left_n  = keys_n[3];
    assign bus.key_right_n = keys_n[4];

    move_input_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .SYNC_STAGES    (SYNC)
    ) dut (
        .clk_25Mhz(clk_25Mhz),
        ._reset   (_reset),
        .bus      (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: a button's level flips once its last DEB synchronised samples all
    // disagree with it; the arbiter acts on the previous cycle's press flags.
    bit [HL-1:0] m_hist [NB];
    bit [NB-1:0] m_level;
    bit [NB-1:0] m_press;
    bit          m_wait;
    int          m_pulse;
    int          m_last;

    int          pulses [NB];
    logic [NB-1:0] obs;

    task automatic model_reset();
        for (int b = 0; b < NB; b++) m_hist[b] = '1;
        m_level = '1;
        m_press = '0;
        m_wait  = 1'b0;
        m_pulse = 0;
        m_last  = 0;
    endtask

    task automatic model_step();
        bit [NB-1:0] new_press;
        bit          all_diff;
        m_pulse = 0;
        if (!m_wait) begin
            for (int b = NB - 1; b >= 0; b--) if (m_press[b]) m_pulse = b + 1;
            if (m_pulse != 0) begin
                m_last = m_pulse;
                m_wait = 1'b1;
            end
        end else if (&m_level) begin
            m_wait = 1'b0;
        end
        for (int b = 0; b < NB; b++) begin
            all_diff = 1'b1;
            for (int k = SYNC - 1; k <= SYNC + DEB - 2; k++)
                if (m_hist[b][k] == m_level[b]) all_diff = 1'b0;
            new_press[b] = all_diff && m_level[b];
            if (all_diff) m_level[b] = ~m_level[b];
            m_hist[b] = {m_hist[b][HL-2:0], keys_n[b]};
        end
        m_press = new_press;
    endtask

    task automatic check_outputs();
        logic [4:0] exp_v;
        exp_v = {m_pulse == 1, m_pulse != 2, m_pulse != 3, m_pulse != 4, m_pulse != 5};
        check("cmd_outputs", {bus.start, bus.mov_up, bus.mov_down, bus.mov_left, bus.mov_right}, exp_v);
        check("last_cmd", 32'(bus.last_cmd), m_last);
        check("busy", bus.busy, m_wait);
        check("one_hot", $countones(obs) <= 1, 1);
    endtask

    // One clock: model advances on the edge, outputs are compared on the falling edge.
    task automatic cycle();
        @(posedge clk_25Mhz);
        if (_reset) model_reset();
        else        model_step();
        @(negedge clk_25Mhz);
        obs = {~bus.mov_right, ~bus.mov_left, ~bus.mov_down, ~bus.mov_up, bus.start};
        for (int b = 0; b < NB; b++) if (obs[b]) pulses[b]++;
        check_outputs();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic clear_pulses();
        for (int b = 0; b < NB; b++) pulses[b] = 0;
    endtask

    task automatic wait_pulse(input int b, input int budget, output int lat);
        lat = -1;
        for (int k = 1; k <= budget; k++) begin
            cycle();
            if (obs[b]) begin
                lat = k;
                break;
            end
        end
    endtask

    int lat;

    initial begin
        model_reset();
        obs = '0;
        clear_pulses();
        run(3);
        check("reset_cmds", {bus.start, bus.mov_up, bus.mov_down, bus.mov_left, bus.mov_right}, 5'b01111);
        check("reset_last", 32'(bus.last_cmd), CMD_NONE);
        check("reset_busy", bus.busy, 0);
        _reset = 1'b0;
        run(4);

        // Clean press and long hold.
        clear_pulses();
        keys_n[3] = 1'b0;
        wait_pulse(3, 20, lat);
        check("s1_latency", lat, 7);
        check("s1_last", 32'(bus.last_cmd), CMD_LEFT);
        check("s1_busy", bus.busy, 1);
        run(100);
        check("s1_no_repeat", pulses[3], 1);
        keys_n = '1;
        run(12);
        check("s1_release", bus.busy, 0);

        // Bounce, then settle low.
        clear_pulses();
        for (int i = 0; i < 20; i++) begin
            keys_n[1] = ((i / 2) % 2) != 0;
            cycle();
        end
        check("s2_no_bounce_pulse", pulses[1], 0);
        keys_n[1] = 1'b0;
        wait_pulse(1, 20, lat);
        check("s2_latency", lat, 7);
        keys_n = '1;
        run(12);

        // Simultaneous down and right.
        clear_pulses();
        keys_n[2] = 1'b0;
        keys_n[4] = 1'b0;
        wait_pulse(2, 20, lat);
        check("s3_latency", lat, 7);
        run(30);
        check("s3_right_silent", pulses[4], 0);
        check("s3_down_once", pulses[2], 1);
        check("s3_last", 32'(bus.last_cmd), CMD_DOWN);
        keys_n = '1;
        run(12);

        // Start held, up pressed during the hold, then up alone.
        clear_pulses();
        keys_n[0] = 1'b0;
        run(3);
        keys_n[1] = 1'b0;
        run(40);
        check("s4_start_once", pulses[0], 1);
        check("s4_up_ignored", pulses[1], 0);
        keys_n = '1;
        run(15);
        keys_n[1] = 1'b0;
        wait_pulse(1, 20, lat);
        check("s4_up_latency", lat, 7);
        check("s4_up_once", pulses[1], 1);
        keys_n = '1;
        run(12);

        // Reset in the middle of a debounce.
        clear_pulses();
        keys_n[3] = 1'b0;
        run(4);
        _reset = 1'b1;
        model_reset();
        #1;
        check("s5_rst_cmds", {bus.start, bus.mov_up, bus.mov_down, bus.mov_left, bus.mov_right}, 5'b01111);
        check("s5_rst_last", 32'(bus.last_cmd), CMD_NONE);
        check("s5_rst_busy", bus.busy, 0);
        @(negedge clk_25Mhz);
        run(2);
        _reset = 1'b0;
        wait_pulse(3, 20, lat);
        check("s5_latency", lat, 7);
        check("s5_left_once", pulses[3], 1);
        keys_n = '1;
        run(12);

        // One-cycle glitch.
        clear_pulses();
        keys_n[4] = 1'b0;
        cycle();
        keys_n[4] = 1'b1;
        run(20);
        check("s6_no_pulse", pulses[4], 0);
        check("s6_busy", bus.busy, 0);

        // Random key traffic with occasional resets.
        for (int s = 0; s < 400; s++) begin
            if ($urandom_range(0, 39) == 0) begin
                _reset = 1'b1;
                model_reset();
                run($urandom_range(1, 2));
                _reset = 1'b0;
            end
            keys_n = NB'($urandom) | NB'($urandom) | NB'($urandom);
            run($urandom_range(1, 8));
        end
        keys_n = '1;
        run(12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/move_input_ctrl.md
Name: move_input_ctrl

Overview:
Input-side conditioner that produces the move and start commands consumed by fsm_2048, which sits opposite the vga_driver_old output path.
- Takes the five raw active-low board push-buttons.
- Synchronises and debounces each button.
- Arbitrates simultaneous presses.
- Emits exactly one single-cycle command per physical press.
Runs entirely in the clk_25Mhz domain and feeds start and mov_left/right/up/down.

Parameters:
DEBOUNCE_CYCLES, 250000, consecutive stable samples needed to accept a level change (10 ms at 25 MHz); must be >= 2
SYNC_STAGES, 2, flip-flop depth of the per-button synchroniser; must be >= 2

Ports:
clk_25Mhz  input  1  system clock; all state is updated on its rising edge
_reset  input  1  asynchronous, active-high reset
key_start_n  input  1  raw start button, active-low, asynchronous to the clock
key_up_n  input  1  raw up button, active-low, asynchronous
key_down_n  input  1  raw down button, active-low, asynchronous
key_left_n  input  1  raw left button, active-low, asynchronous
key_right_n  input  1  raw right button, active-low, asynchronous
start  output  1  one-cycle active-high start command
mov_up  output  1  one-cycle active-low move command
mov_down  output  1  one-cycle active-low move command
mov_left  output  1  one-cycle active-low move command
mov_right  output  1  one-cycle active-low move command
last_cmd  output  3  code of the most recently issued command (package enum)
busy  output  1  high while waiting for all buttons to be released

Behaviour:
Reset values:
- start=0; all mov_*=1; last_cmd=CMD_NONE; busy=0.
- Synchroniser flops preset to 1 (released).
- Debounced levels = 1; debounce counters = 0; FSM = IDLE.
- Reset is honoured at any time, including mid-debounce or mid-pulse. Outputs return to reset values immediately. No pulse may be emitted in the cycle reset deasserts.

Per button:
- The synchronised sample is compared with the debounced level.
- If they differ, the counter increments. When the counter reaches DEBOUNCE_CYCLES-1 while they still differ, the debounced level takes the new value and the counter clears.
- If they are equal, the counter clears. Any bounce restarts the count.
- Press event = debounced level 1->0 (one-cycle flag).

FSM states:
- IDLE:
  - If any press event occurs, the winner is chosen by fixed priority start > up > down > left > right.
  - The next cycle asserts exactly that one output (start=1 or mov_x=0) for one cycle.
  - last_cmd is updated in the same cycle as the pulse.
  - Go to WAIT_RELEASE.
  - Losing simultaneous presses are discarded, never queued.
- WAIT_RELEASE:
  - busy=1; no command is emitted.
  - Further press events are ignored.
  - When all five debounced levels are 1, go to IDLE; busy drops that cycle.

Timing:
- Latency from the first raw low sample to the output pulse = SYNC_STAGES + DEBOUNCE_CYCLES + 1 rising edges.
- Holding a button never repeats the command. A new command requires full release of all buttons, then a new press.

Output and width rules:
- At most one command output is active in any cycle.
- Pulse width is exactly 1 cycle.
- Counter width = $clog2(DEBOUNCE_CYCLES). No wrap is possible because the counter clears at its terminal count.

Decomposition:
Package move_input_pkg holds:
- typedef enum logic [2:0] cmd_t: CMD_NONE, CMD_START, CMD_UP, CMD_DOWN, CMD_LEFT, CMD_RIGHT.
- The state enum: IDLE, WAIT_RELEASE.
- The priority order constant.

Sub-module button_debouncer (synchroniser + counter + press flag, parameterised by DEBOUNCE_CYCLES and SYNC_STAGES) is instantiated 5 times. The top level holds the arbiter FSM and output registers.

Test Plan:
All runs use DEBOUNCE_CYCLES=4, SYNC_STAGES=2.
1. Clean press: key_left_n 1->0 and held -> mov_left=0 for exactly 1 cycle, 7 edges after the first low sample. last_cmd=CMD_LEFT; busy=1 until release is debounced; no repeat over 100 cycles of hold.
2. Bounce: key_up_n toggles 0/1 every 2 cycles for 20 cycles, then stays 0 -> no pulse during bouncing; a single mov_up pulse 4+3 cycles after the level settles.
3. Simultaneous: key_right_n and key_down_n fall in the same cycle -> only mov_down pulses; mov_right stays 1 throughout; last_cmd=CMD_DOWN.
4. Overlap: hold key_start_n, then press key_up_n while start is still held -> one start pulse only. After releasing both and pressing key_up_n alone -> one mov_up pulse.
5. Reset mid-operation: assert _reset during cycle 3 of debouncing key_left_n, release after 2 cycles with the key still low -> all outputs at reset values during reset. A full debounce restarts, then one mov_left pulse 7 edges after reset release.
6. Glitch: key_right_n low for 1 cycle only -> no output; counter returns to 0; busy stays 0.
